// File: rtl/payload_feed_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : payload_feed_arbiter_pkg
//  Description : Shared types for the payload feed arbiter: FSM state
//                encoding, abort cause and byte size.
//  Revision    : 1.0 - initial release
// ============================================================================
package payload_feed_arbiter_pkg;

    localparam int BYTE_LENGTH = 8;

    // Arbiter FSM states, explicitly encoded
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FORWARD = 2'd1,
        DRAIN   = 2'd2,
        ABORT   = 2'd3
    } arb_state_t;

    // Why the current abort beat is being emitted; selects the post-abort state
    typedef enum logic {
        ABORT_TRUNC   = 1'b0,   // new SOP arrived mid-payload -> back to IDLE
        ABORT_OVERRUN = 1'b1    // payload exceeded MAX_BEATS   -> DRAIN the rest
    } abort_cause_t;

endpackage
`default_nettype wire

// File: rtl/payload_feed_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : payload_feed_arbiter_rr_arbiter
//  Description : Combinational round-robin picker. Searches upward starting
//                one position after ptr_i (wrapping) and returns the first
//                requester as one-hot, index and an any-request flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module payload_feed_arbiter_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] w_pos;

    // First requester after the pointer wins; the pointer itself is checked last
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        w_pos = '0;
        for (int k = 1; k <= N; k++) begin
            w_pos = IDX_W'((int'(ptr_i) + k) % N);
            if (!any_o && req_i[w_pos]) begin
                any_o        = 1'b1;
                idx_o        = w_pos;
                gnt_o[w_pos] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/payload_feed_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : payload_feed_arbiter
//  Description : Packet-atomic round-robin arbiter feeding one decoder
//                ingress from NUM_FEEDS payload feeds. Drops orphan beats,
//                force-terminates truncated or runaway payloads with an
//                error beat so payloads never interleave.
//  Revision    : 1.0 - initial release
// ============================================================================
module payload_feed_arbiter
    import payload_feed_arbiter_pkg::*;
#(
    parameter int NUM_FEEDS     = 4,
    parameter int IN_DATA_WIDTH = 64,
    parameter int EMPTY_WIDTH   = 3,
    parameter int MAX_BEATS     = 256,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_FEEDS-1:0]             feedEnable,
    input  logic [NUM_FEEDS-1:0]             reqValid,
    input  logic [NUM_FEEDS-1:0]             reqStartOfPayload,
    input  logic [NUM_FEEDS-1:0]             reqEndOfPayload,
    input  logic [NUM_FEEDS*IN_DATA_WIDTH-1:0] reqData,
    input  logic [NUM_FEEDS*EMPTY_WIDTH-1:0] reqEmpty,
    input  logic [NUM_FEEDS-1:0]             reqError,
    output logic [NUM_FEEDS-1:0]             reqReady,
    output logic                             outValid,
    output logic                             outStartOfPayload,
    output logic                             outEndOfPayload,
    output logic                             outError,
    output logic [IN_DATA_WIDTH-1:0]         outData,
    output logic [EMPTY_WIDTH-1:0]           outEmpty,
    input  logic                             outReady,
    output logic                             grantActive,
    output logic [$clog2(NUM_FEEDS)-1:0]     grantFeedId,
    output logic [CNT_WIDTH-1:0]             dropCount,
    output logic [CNT_WIDTH-1:0]             abortCount
);

    localparam int                     IDX_W       = $clog2(NUM_FEEDS);
    localparam int                     BCNT_W      = $clog2(MAX_BEATS + 1);
    localparam logic [BCNT_W-1:0]      C_MAX_BEATS = BCNT_W'(MAX_BEATS);
    localparam logic [CNT_WIDTH-1:0]   C_CNT_SAT   = '1;

    typedef struct packed {
        logic                     sop;
        logic                     eop;
        logic [IN_DATA_WIDTH-1:0] data;
        logic [EMPTY_WIDTH-1:0]   empty;
        logic                     error;
    } feed_beat_t;

    arb_state_t             state_q, state_d;
    abort_cause_t           cause_q, cause_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [BCNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CNT_WIDTH-1:0]   abort_cnt_q, abort_cnt_d;

    logic [IN_DATA_WIDTH-1:0] w_data_arr  [NUM_FEEDS];
    logic [EMPTY_WIDTH-1:0]   w_empty_arr [NUM_FEEDS];
    logic [NUM_FEEDS-1:0]     w_cand, w_rr_gnt;
    logic [IDX_W-1:0]         w_rr_idx;
    logic                     w_rr_any;
    feed_beat_t               w_g_beat;
    logic                     w_g_valid, w_trunc, w_fwd_hs;
    logic [BCNT_W-1:0]        w_beat_cnt_inc;

    // Unpack the flat per-feed buses into indexable arrays
    generate
        for (genvar i = 0; i < NUM_FEEDS; i++) begin : g_unpack
            assign w_data_arr[i]  = reqData[i*IN_DATA_WIDTH +: IN_DATA_WIDTH];
            assign w_empty_arr[i] = reqEmpty[i*EMPTY_WIDTH +: EMPTY_WIDTH];
        end
    endgenerate

    // Enable only gates new grants; a granted feed keeps its grant regardless
    assign w_cand = reqValid & feedEnable;

    payload_feed_arbiter_rr_arbiter #(
        .N     (NUM_FEEDS),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i (w_cand),
        .ptr_i (rr_ptr_q),
        .gnt_o (w_rr_gnt),
        .idx_o (w_rr_idx),
        .any_o (w_rr_any)
    );

    assign w_g_valid      = reqValid[grant_q];
    assign w_g_beat.sop   = reqStartOfPayload[grant_q];
    assign w_g_beat.eop   = reqEndOfPayload[grant_q];
    assign w_g_beat.data  = w_data_arr[grant_q];
    assign w_g_beat.empty = w_empty_arr[grant_q];
    assign w_g_beat.error = reqError[grant_q];

    // A SOP after the first beat means the feed restarted: hold it back and abort
    assign w_trunc        = (state_q == FORWARD) && w_g_valid && w_g_beat.sop && (beat_cnt_q != '0);
    assign w_fwd_hs       = (state_q == FORWARD) && !w_trunc && w_g_valid && outReady;
    assign w_beat_cnt_inc = beat_cnt_q + 1'b1;

    // State register and all sequential bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cause_q     <= ABORT_TRUNC;
            grant_q     <= '0;
            rr_ptr_q    <= IDX_W'(NUM_FEEDS - 1);
            beat_cnt_q  <= '0;
            drop_cnt_q  <= '0;
            abort_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    // Next-state logic: grant, payload tracking, abort decisions, counters
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        abort_cnt_d = abort_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (w_rr_any) begin
                    grant_d    = w_rr_idx;
                    beat_cnt_d = '0;
                    if (|(w_rr_gnt & reqStartOfPayload)) begin
                        state_d = FORWARD;
                    end else begin
                        state_d = DRAIN;
                        if (drop_cnt_q != C_CNT_SAT) drop_cnt_d = drop_cnt_q + 1'b1;
                    end
                end
            end
            FORWARD: begin
                if (w_trunc) begin
                    state_d = ABORT;
                    cause_d = ABORT_TRUNC;
                end else if (w_fwd_hs) begin
                    beat_cnt_d = w_beat_cnt_inc;
                    if (w_g_beat.eop) begin
                        state_d  = IDLE;
                        rr_ptr_d = grant_q;
                    end else if (w_beat_cnt_inc == C_MAX_BEATS) begin
                        state_d = ABORT;
                        cause_d = ABORT_OVERRUN;
                    end
                end
            end
            DRAIN: begin
                if (w_g_valid && w_g_beat.eop) begin
                    state_d  = IDLE;
                    rr_ptr_d = grant_q;
                end
            end
            ABORT: begin
                if (outReady) begin
                    rr_ptr_d = grant_q;
                    state_d  = (cause_q == ABORT_TRUNC) ? IDLE : DRAIN;
                    if (abort_cnt_q != C_CNT_SAT) abort_cnt_d = abort_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: pass-through mux, synthetic abort beat, drain sink
    always_comb begin
        reqReady          = '0;
        outValid          = 1'b0;
        outStartOfPayload = 1'b0;
        outEndOfPayload   = 1'b0;
        outError          = 1'b0;
        outData           = '0;
        outEmpty          = '0;
        unique case (state_q)
            FORWARD: begin
                if (!w_trunc) begin
                    outValid          = w_g_valid;
                    outStartOfPayload = w_g_beat.sop;
                    outEndOfPayload   = w_g_beat.eop;
                    outError          = w_g_beat.error;
                    outData           = w_g_beat.data;
                    outEmpty          = w_g_beat.empty;
                    reqReady[grant_q] = outReady;
                end
            end
            ABORT: begin
                outValid        = 1'b1;
                outEndOfPayload = 1'b1;
                outError        = 1'b1;
            end
            DRAIN: begin
                reqReady[grant_q] = 1'b1;
            end
            default: begin
                reqReady = '0;
            end
        endcase
    end

    assign grantActive = (state_q == FORWARD) || (state_q == DRAIN);
    assign grantFeedId = grant_q;
    assign dropCount   = drop_cnt_q;
    assign abortCount  = abort_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_payload_feed_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_payload_feed_arbiter
//  Description : Scoreboard bench for payload_feed_arbiter. Feed streams are
//                loaded as beat queues; a packet-level model predicts the
//                decoder-side beat stream and counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_payload_feed_arbiter;

    localparam int NF = 4;
    localparam int DW = 32;
    localparam int EW = 3;
    localparam int MB = 4;
    localparam int CW = 16;
    localparam int IW = $clog2(NF);
    localparam int BW = 3 + EW + DW;

    typedef struct {
        logic          sop;
        logic          eop;
        logic          err;
        logic [DW-1:0] data;
        logic [EW-1:0] empty;
    } beat_t;

    typedef struct {
        beat_t b;
        bit    is_abort;
        int    id;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [NF-1:0]    feedEnable, reqValid, reqSop, reqEop, reqError, reqReady;
    logic [NF*DW-1:0] reqData;
    logic [NF*EW-1:0] reqEmpty;
    logic             outValid, outSop, outEop, outError, outReady;
    logic [DW-1:0]    outData;
    logic [EW-1:0]    outEmpty;
    logic             grantActive;
    logic [IW-1:0]    grantFeedId;
    logic [CW-1:0]    dropCount, abortCount;

    beat_t fq [NF][$];
    exp_t  sb [$];
    int    n_vec = 0, n_err = 0;
    int    m_ptr = NF - 1, m_drop = 0, m_abort = 0;
    int    rdy_mode = 1;
    bit    chk_gap = 0;
    int    cyc = 0, last_eop = 0;
    bit    have_last = 0;

    payload_feed_arbiter #(
        .NUM_FEEDS(NF), .IN_DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .MAX_BEATS(MB), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .feedEnable(feedEnable),
        .reqValid(reqValid), .reqStartOfPayload(reqSop), .reqEndOfPayload(reqEop),
        .reqData(reqData), .reqEmpty(reqEmpty), .reqError(reqError), .reqReady(reqReady),
        .outValid(outValid), .outStartOfPayload(outSop), .outEndOfPayload(outEop),
        .outError(outError), .outData(outData), .outEmpty(outEmpty), .outReady(outReady),
        .grantActive(grantActive), .grantFeedId(grantFeedId),
        .dropCount(dropCount), .abortCount(abortCount)
    );

    always #5 clk = ~clk;

    function automatic void chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic drive_inputs(input logic tog);
        for (int i = 0; i < NF; i++) begin
            if (fq[i].size() > 0) begin
                reqValid[i] = 1'b1;
                reqSop[i]   = fq[i][0].sop;
                reqEop[i]   = fq[i][0].eop;
                reqError[i] = fq[i][0].err;
                reqData[i*DW +: DW] = fq[i][0].data;
                reqEmpty[i*EW +: EW] = fq[i][0].empty;
            end else begin
                reqValid[i] = 1'b0;
                reqSop[i]   = 1'b0;
                reqEop[i]   = 1'b0;
                reqError[i] = 1'b0;
                reqData[i*DW +: DW] = '0;
                reqEmpty[i*EW +: EW] = '0;
            end
        end
        case (rdy_mode)
            1:       outReady = 1'b1;
            2:       outReady = tog;
            3:       outReady = 1'b0;
            default: outReady = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic add_pkt(input int f, input int len, input bit orphan, input int tpos);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            b.sop   = (j == 0 && !orphan) || (j == tpos);
            b.eop   = (j == len - 1);
            b.err   = ($urandom_range(0, 7) == 0);
            b.data  = $urandom;
            b.empty = EW'($urandom_range(0, 7));
            fq[f].push_back(b);
        end
    endtask

    task automatic push_abort(input int g);
        exp_t e;
        e.b.sop = 1'b0; e.b.eop = 1'b1; e.b.err = 1'b1; e.b.data = '0; e.b.empty = '0;
        e.is_abort = 1'b1;
        e.id = g;
        sb.push_back(e);
        m_abort++;
        m_ptr = g;
    endtask

    // Packet-level reference: whole payloads chosen round-robin from the pending streams
    task automatic run_model(input logic [NF-1:0] en);
        beat_t mq [NF][$];
        beat_t b;
        exp_t  e;
        int    g, n, j;
        bit    found;
        for (int i = 0; i < NF; i++) mq[i] = fq[i];
        g = 0;
        forever begin
            found = 0;
            for (int k = 1; k <= NF; k++) begin
                j = (m_ptr + k) % NF;
                if (!found && en[j] && mq[j].size() > 0) begin
                    found = 1;
                    g = j;
                end
            end
            if (!found) break;
            if (!mq[g][0].sop) begin
                m_drop++;
                while (mq[g].size() > 0) begin
                    b = mq[g].pop_front();
                    if (b.eop) break;
                end
                m_ptr = g;
                continue;
            end
            n = 0;
            while (mq[g].size() > 0) begin
                b = mq[g][0];
                if (n > 0 && b.sop) begin
                    push_abort(g);
                    break;
                end
                void'(mq[g].pop_front());
                e.b = b; e.is_abort = 1'b0; e.id = g;
                sb.push_back(e);
                n++;
                if (b.eop) begin
                    m_ptr = g;
                    break;
                end
                if (n == MB) begin
                    push_abort(g);
                    while (mq[g].size() > 0) begin
                        b = mq[g].pop_front();
                        if (b.eop) break;
                    end
                    break;
                end
            end
        end
    endtask

    task automatic flush_all();
        for (int i = 0; i < NF; i++) fq[i].delete();
        sb.delete();
    endtask

    task automatic wait_done(input string tag);
        int  t;
        bit  busy;
        t = 0;
        forever begin
            @(posedge clk); #2;
            busy = (sb.size() > 0);
            for (int i = 0; i < NF; i++) if (feedEnable[i] && fq[i].size() > 0) busy = 1;
            if (!busy) break;
            t++;
            if (t > 1000) begin
                chk(0, {tag, "_timeout"}, 64'(sb.size()), 64'd0);
                break;
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(!grantActive && !outValid, {tag, "_idle"}, 64'({grantActive, outValid}), 64'd0);
        chk(dropCount == CW'(m_drop), {tag, "_dropCount"}, 64'(dropCount), 64'(m_drop));
        chk(abortCount == CW'(m_abort), {tag, "_abortCount"}, 64'(abortCount), 64'(m_abort));
        @(posedge clk); #2;
        flush_all();
    endtask

    // Feed driver: retire beats that handshook, then present the next heads
    initial begin : drv
        logic [NF-1:0] fire;
        logic          tog;
        tog = 1'b0;
        drive_inputs(tog);
        forever begin
            @(negedge clk);
            fire = reqValid & reqReady;
            @(posedge clk); #1;
            for (int i = 0; i < NF; i++)
                if (fire[i] && fq[i].size() > 0) void'(fq[i].pop_front());
            tog = ~tog;
            drive_inputs(tog);
        end
    end

    // Monitor: compare every accepted output beat against the scoreboard head
    initial begin : mon
        logic [BW-1:0] act, expv, prev_act;
        logic [NF-1:0] mask;
        bit            prev_stall;
        exp_t          e;
        prev_stall = 0;
        prev_act   = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!chk_gap) have_last = 0;
            if (reset) begin
                prev_stall = 0;
                continue;
            end
            act = {outSop, outEop, outError, outEmpty, outData};
            if (prev_stall)
                chk(outValid && act == prev_act, "stall_hold", 64'(act), 64'(prev_act));
            mask = '1;
            if (grantActive) mask[grantFeedId] = 1'b0;
            chk((reqReady & mask) == '0, "ready_isolation", 64'(reqReady), 64'(reqReady & ~mask));
            if (outValid && outReady) begin
                if (sb.size() == 0) begin
                    chk(0, "unexpected_beat", 64'(act), 64'd0);
                end else begin
                    e = sb.pop_front();
                    if (e.is_abort) expv = {1'b0, 1'b1, 1'b1, {EW{1'b0}}, {DW{1'b0}}};
                    else            expv = {e.b.sop, e.b.eop, e.b.err, e.b.empty, e.b.data};
                    chk(act == expv, e.is_abort ? "abort_beat" : "fwd_beat", 64'(act), 64'(expv));
                    if (!e.is_abort)
                        chk(int'(grantFeedId) == e.id, "grant_id", 64'(grantFeedId), 64'(e.id));
                    if (chk_gap && e.b.sop && !e.is_abort && have_last)
                        chk(cyc - last_eop == 2, "sop_gap", 64'(cyc - last_eop), 64'd2);
                    if (outEop) begin
                        last_eop  = cyc;
                        have_last = 1;
                    end
                end
            end
            prev_stall = outValid && !outReady;
            prev_act   = act;
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: time limit reached, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t, npk, len, tpos;
        feedEnable = '0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk(reqReady == '0, "rst_reqReady", 64'(reqReady), 64'd0);
        chk(!outValid && !outSop && !outEop && !outError, "rst_outctl",
            64'({outValid, outSop, outEop, outError}), 64'd0);
        chk(outData == '0 && outEmpty == '0, "rst_outdata", 64'(outData), 64'd0);
        chk(!grantActive, "rst_grantActive", 64'(grantActive), 64'd0);
        chk(grantFeedId == '0, "rst_grantFeedId", 64'(grantFeedId), 64'd0);
        chk(dropCount == '0 && abortCount == '0, "rst_counters",
            64'({dropCount, abortCount}), 64'd0);
        @(posedge clk); #3;
        reset = 1'b0;

        // Three simultaneous 3-beat payloads, decoder always ready
        @(posedge clk); #2;
        rdy_mode = 1; chk_gap = 1; feedEnable = '1;
        add_pkt(0, 3, 0, -1); add_pkt(1, 3, 0, -1); add_pkt(2, 3, 0, -1);
        run_model(feedEnable);
        wait_done("s1");
        chk_gap = 0;

        // Feed 1, 4 beats, decoder ready toggling
        @(posedge clk); #2;
        rdy_mode = 2;
        add_pkt(1, 4, 0, -1);
        run_model(feedEnable);
        wait_done("s2");

        // Feed 2 orphan payload
        @(posedge clk); #2;
        rdy_mode = 0;
        add_pkt(2, 3, 1, -1);
        run_model(feedEnable);
        wait_done("s3");

        // Feed 0 runaway payload, 6 beats against MAX_BEATS=4
        @(posedge clk); #2;
        add_pkt(0, 6, 0, -1);
        run_model(feedEnable);
        wait_done("s4");

        // Feed 3 truncated payload followed by a complete one
        @(posedge clk); #2;
        add_pkt(3, 5, 0, 2);
        run_model(feedEnable);
        wait_done("s5");

        // Asynchronous reset while a payload is stalled mid-FORWARD
        @(posedge clk); #2;
        rdy_mode = 3;
        add_pkt(2, 3, 0, -1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!grantActive && t < 50);
        chk(grantActive && outValid, "s6_stalled", 64'({grantActive, outValid}), 64'd3);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk(!outValid, "s6_async_outValid", 64'(outValid), 64'd0);
        chk(reqReady == '0, "s6_async_reqReady", 64'(reqReady), 64'd0);
        chk(!grantActive, "s6_async_grantActive", 64'(grantActive), 64'd0);
        @(posedge clk); #2;
        flush_all();
        m_ptr = NF - 1; m_drop = 0; m_abort = 0;
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk); #2;
        add_pkt(2, 1, 0, -1); add_pkt(1, 2, 0, -1); add_pkt(0, 2, 0, -1);
        run_model(feedEnable);
        wait_done("s6_after");

        // Randomised traffic mixes
        for (int it = 0; it < 20; it++) begin
            @(posedge clk); #2;
            rdy_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
            for (int i = 0; i < NF; i++) begin
                feedEnable[i] = ($urandom_range(0, 3) != 0);
                npk = $urandom_range(0, 2);
                for (int p = 0; p < npk; p++) begin
                    len  = $urandom_range(1, 6);
                    tpos = (len >= 2 && $urandom_range(0, 5) == 0) ? $urandom_range(1, len - 1) : -1;
                    add_pkt(i, len, ($urandom_range(0, 9) == 0), tpos);
                end
            end
            run_model(feedEnable);
            wait_done("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
